// File: rtl/irq_ctrl_6502_if.sv
// Core-side register bus between core_6502 and irq_ctrl_6502.
// The core drives address, data and strobes; the controller returns read data.
interface irq_ctrl_6502_if;
    logic [15:0] addr_pin;
    logic [7:0]  wdata;
    logic        we_pin;
    logic        rd_pin;
    logic [7:0]  rdata;
    logic        rdata_oe;

    modport master (
        output addr_pin,
        output wdata,
        output we_pin,
        output rd_pin,
        input  rdata,
        input  rdata_oe
    );

    modport slave (
        input  addr_pin,
        input  wdata,
        input  we_pin,
        input  rd_pin,
        output rdata,
        output rdata_oe
    );
endinterface

// File: rtl/irq_ctrl_6502.sv
// Memory-mapped IRQ/NMI controller for core_6502: synchronises sources, applies
// mode/polarity/enable, holds pending state and drives the core's irq/nmi pins.
module irq_ctrl_6502 #(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int unsigned NUM_SRC   = 8
) (
    input  logic               clk,
    input  logic               reset,
    irq_ctrl_6502_if.slave     bus,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               nmi_src,
    output logic               irq_out,
    output logic               nmi_out
);
    localparam int unsigned   DW          = 8;
    localparam logic [DW:0]   SRC_ONE_HOT = 9'd1 << NUM_SRC;
    localparam logic [DW-1:0] IMPL_MASK   = DW'(SRC_ONE_HOT - 9'd1);

    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_MODE     = 3'd2;
    localparam logic [2:0] OFF_POLARITY = 3'd3;
    localparam logic [2:0] OFF_VECTOR   = 3'd4;
    localparam logic [2:0] OFF_NMI_CTRL = 3'd5;
    localparam logic [2:0] OFF_SWSET    = 3'd6;

    logic [DW-1:0] src_ext;
    logic [DW-1:0] s1, s2, s3;
    logic          n1, n2, n3;
    logic [DW-1:0] pending, enable, mode, polarity;
    logic          nmi_en, nmi_pend;

    logic          cs;
    logic [2:0]    off;
    logic          wr_hit, rd_hit;
    logic [DW-1:0] act, act_prev, edge_set, w1c, swset, pending_nxt, active;
    logic          nmi_edge, nmi_clr, nmi_pend_nxt;
    logic          vec_any;
    logic [2:0]    vec_idx;
    logic [DW-1:0] rd_data;

    assign src_ext = DW'(irq_src);

    // Address decode; a simultaneous read and write is treated as a write only
    assign cs     = (bus.addr_pin[15:3] == BASE_ADDR[15:3]);
    assign off    = bus.addr_pin[2:0];
    assign wr_hit = bus.we_pin & cs;
    assign rd_hit = bus.rd_pin & cs & ~bus.we_pin;

    // Activity is always judged under the current polarity, so changing
    // polarity shifts s2 and s3 together and cannot fabricate an edge.
    assign act      = ~(s2 ^ polarity);
    assign act_prev = ~(s3 ^ polarity);
    assign edge_set = act & ~act_prev;

    assign w1c   = (wr_hit && off == OFF_PENDING) ? (bus.wdata & mode) : '0;
    assign swset = (wr_hit && off == OFF_SWSET)   ? (bus.wdata & mode) : '0;

    // Edge bits: sticky with set beating clear; level bits follow act directly
    assign pending_nxt = ((((pending & ~w1c) | edge_set | swset) & mode)
                         | (act & ~mode)) & IMPL_MASK;

    assign nmi_edge     = n2 & ~n3;
    assign nmi_clr      = wr_hit && (off == OFF_NMI_CTRL) && bus.wdata[1];
    assign nmi_pend_nxt = (nmi_pend & ~nmi_clr) | nmi_edge;

    assign active  = pending & enable;
    assign vec_any = |active;

    // Lowest-numbered active source wins
    always_comb begin
        vec_idx = 3'd0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 3'(i);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_PENDING:  rd_data = pending;
            OFF_ENABLE:   rd_data = enable;
            OFF_MODE:     rd_data = mode;
            OFF_POLARITY: rd_data = polarity;
            OFF_VECTOR:   rd_data = vec_any ? {1'b1, 4'b0000, vec_idx} : '0;
            OFF_NMI_CTRL: rd_data = {6'b000000, nmi_pend, nmi_en};
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            s3           <= '0;
            n1           <= 1'b0;
            n2           <= 1'b0;
            n3           <= 1'b0;
            pending      <= '0;
            enable       <= '0;
            mode         <= IMPL_MASK;
            polarity     <= IMPL_MASK;
            nmi_en       <= 1'b0;
            nmi_pend     <= 1'b0;
            irq_out      <= 1'b0;
            nmi_out      <= 1'b0;
            bus.rdata    <= '0;
            bus.rdata_oe <= 1'b0;
        end else begin
            s1       <= src_ext & IMPL_MASK;
            s2       <= s1;
            s3       <= s2;
            n1       <= nmi_src;
            n2       <= n1;
            n3       <= n2;
            pending  <= pending_nxt;
            nmi_pend <= nmi_pend_nxt;
            irq_out  <= vec_any;
            nmi_out  <= nmi_pend & nmi_en;

            if (wr_hit) begin
                case (off)
                    OFF_ENABLE:   enable   <= bus.wdata & IMPL_MASK;
                    OFF_MODE:     mode     <= bus.wdata & IMPL_MASK;
                    OFF_POLARITY: polarity <= bus.wdata & IMPL_MASK;
                    OFF_NMI_CTRL: nmi_en   <= bus.wdata[0];
                    default: ;
                endcase
            end

            // rdata keeps its last value; only the drive enable is one-shot
            if (rd_hit) begin
                bus.rdata    <= rd_data;
                bus.rdata_oe <= 1'b1;
            end else begin
                bus.rdata_oe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_irq_ctrl_6502.sv
// Bench for irq_ctrl_6502: register tables, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_irq_ctrl_6502;
    localparam int unsigned NSRC = 8;
    localparam logic [15:0] BASE = 16'hD000;
    localparam int          RCYC = 1500;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic            nmi_src;
    logic            irq_out;
    logic            nmi_out;

    irq_ctrl_6502_if bus ();

    irq_ctrl_6502 #(.BASE_ADDR(BASE), .NUM_SRC(NSRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_src (irq_src),
        .nmi_src (nmi_src),
        .irq_out (irq_out),
        .nmi_out (nmi_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] off;
        logic       do_wr;
        logic [7:0] wval;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [7:0] m_pend, m_en, m_mode, m_pol, m_rdata, np;
    logic       m_nen, m_npend, m_irq, m_nmi, m_oe, nnp;
    logic [8:0] hist [0:RCYC-1];
    logic [8:0] cur, prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.we_pin = 1'b0;
        bus.rd_pin = 1'b0;
        irq_src    = '0;
        nmi_src    = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        bus.addr_pin = BASE | 16'(off);
        bus.wdata    = d;
        bus.we_pin   = 1'b1;
        tick();
        bus.we_pin = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] exp);
        bus.addr_pin = BASE | 16'(off);
        bus.rd_pin   = 1'b1;
        tick();
        bus.rd_pin = 1'b0;
        check({name, "_oe"}, 32'(bus.rdata_oe), 32'd1);
        check(name, 32'(bus.rdata), 32'(exp));
    endtask

    function automatic logic [7:0] m_reg(input logic [2:0] off);
        logic [7:0] a;
        logic       found;
        logic [2:0] idx;
        a     = m_pend & m_en;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        case (off)
            3'd0:    return m_pend;
            3'd1:    return m_en;
            3'd2:    return m_mode;
            3'd3:    return m_pol;
            3'd4:    return found ? {1'b1, 4'b0000, idx} : 8'h00;
            3'd5:    return {6'b000000, m_npend, m_nen};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        logic        we, rdv, cs_m, w, rr;
        logic [7:0]  d;
        logic [2:0]  off;
        logic        a_now, a_prv;

        bus.addr_pin = '0;
        bus.wdata    = '0;
        do_reset();

        check("rst_irq_out", 32'(irq_out), 32'd0);
        check("rst_nmi_out", 32'(nmi_out), 32'd0);
        check("rst_rdata_oe", 32'(bus.rdata_oe), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);

        // reset values, then write/readback including restores
        vecs.push_back('{3'd0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd2, 1'b0, 8'h00, 8'hFF});
        vecs.push_back('{3'd3, 1'b0, 8'h00, 8'hFF});
        vecs.push_back('{3'd4, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd5, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd6, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd7, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{3'd1, 1'b1, 8'hA5, 8'hA5});
        vecs.push_back('{3'd2, 1'b1, 8'h3C, 8'h3C});
        vecs.push_back('{3'd2, 1'b1, 8'hFF, 8'hFF});
        vecs.push_back('{3'd3, 1'b1, 8'h0F, 8'h0F});
        vecs.push_back('{3'd3, 1'b1, 8'hFF, 8'hFF});
        vecs.push_back('{3'd5, 1'b1, 8'hFF, 8'h01});
        vecs.push_back('{3'd7, 1'b1, 8'hFF, 8'h00});
        vecs.push_back('{3'd6, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{3'd1, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{3'd5, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{3'd0, 1'b0, 8'h00, 8'h00});
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].off, vecs[i].wval);
            rd_chk($sformatf("tbl%0d", i), vecs[i].off, vecs[i].exp);
        end

        // single-cycle pulse: pending at k+2, irq_out at k+3
        do_reset();
        wr(3'd1, 8'h0C);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        check("pulse_k0", 32'(irq_out), 32'd0);
        tick();
        check("pulse_k1", 32'(irq_out), 32'd0);
        tick();
        check("pulse_k2", 32'(irq_out), 32'd0);
        tick();
        check("pulse_k3", 32'(irq_out), 32'd1);
        rd_chk("pulse_pend", 3'd0, 8'h08);
        rd_chk("pulse_vec", 3'd4, 8'h83);
        wr(3'd0, 8'h08);
        check("w1c_irq_lag", 32'(irq_out), 32'd1);
        tick();
        check("w1c_irq_drop", 32'(irq_out), 32'd0);

        // priority between two simultaneous sources
        do_reset();
        wr(3'd1, 8'hFF);
        irq_src = 8'h0C;
        repeat (4) tick();
        rd_chk("prio_vec2", 3'd4, 8'h82);
        wr(3'd0, 8'h04);
        rd_chk("prio_vec3", 3'd4, 8'h83);
        wr(3'd0, 8'h08);
        rd_chk("prio_none", 3'd4, 8'h00);
        repeat (3) tick();
        rd_chk("prio_no_rearm", 3'd0, 8'h00);

        // active-low level source on bit 0
        do_reset();
        wr(3'd2, 8'hFE);
        wr(3'd3, 8'hFE);
        wr(3'd1, 8'h01);
        repeat (3) tick();
        rd_chk("lvl_pend", 3'd0, 8'h01);
        check("lvl_irq", 32'(irq_out), 32'd1);
        wr(3'd0, 8'h01);
        rd_chk("lvl_w1c_ignored", 3'd0, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        tick();
        rd_chk("lvl_hold", 3'd0, 8'h01);
        rd_chk("lvl_clear", 3'd0, 8'h00);

        // set beats clear when an edge lands on the W1C cycle
        do_reset();
        irq_src[5] = 1'b1;
        tick();
        tick();
        wr(3'd0, 8'h20);
        rd_chk("set_wins", 3'd0, 8'h20);
        wr(3'd6, 8'h40);
        rd_chk("swset", 3'd0, 8'h60);

        // NMI edge, clear, and no re-assert while held high
        do_reset();
        wr(3'd5, 8'h01);
        nmi_src = 1'b1;
        tick();
        check("nmi_k0", 32'(nmi_out), 32'd0);
        tick();
        check("nmi_k1", 32'(nmi_out), 32'd0);
        tick();
        check("nmi_k2", 32'(nmi_out), 32'd0);
        tick();
        check("nmi_k3", 32'(nmi_out), 32'd1);
        wr(3'd5, 8'h03);
        check("nmi_clr_lag", 32'(nmi_out), 32'd1);
        tick();
        check("nmi_clr", 32'(nmi_out), 32'd0);
        repeat (5) tick();
        check("nmi_held_no_edge", 32'(nmi_out), 32'd0);
        rd_chk("nmi_ctrl", 3'd5, 8'h01);

        // bus corner cases
        do_reset();
        rd_chk("oe_pulse_rd", 3'd2, 8'hFF);
        tick();
        check("oe_drop", 32'(bus.rdata_oe), 32'd0);
        check("rdata_hold", 32'(bus.rdata), 32'hFF);
        bus.addr_pin = BASE | 16'd1;
        bus.wdata    = 8'h55;
        bus.we_pin   = 1'b1;
        bus.rd_pin   = 1'b1;
        tick();
        bus.we_pin = 1'b0;
        bus.rd_pin = 1'b0;
        check("rw_no_read", 32'(bus.rdata_oe), 32'd0);
        rd_chk("rw_write_won", 3'd1, 8'h55);
        bus.addr_pin = 16'hD009;
        bus.wdata    = 8'hAA;
        bus.we_pin   = 1'b1;
        tick();
        bus.we_pin   = 1'b0;
        bus.addr_pin = 16'hCFFA;
        bus.rd_pin   = 1'b1;
        tick();
        bus.rd_pin = 1'b0;
        check("out_of_window_rd", 32'(bus.rdata_oe), 32'd0);
        rd_chk("out_of_window_wr", 3'd1, 8'h55);
        bus.addr_pin = BASE | 16'd2;
        bus.rd_pin   = 1'b1;
        reset        = 1'b1;
        tick();
        reset      = 1'b0;
        bus.rd_pin = 1'b0;
        check("rst_mid_read_oe", 32'(bus.rdata_oe), 32'd0);
        check("rst_mid_read_rdata", 32'(bus.rdata), 32'd0);

        // randomized run against the reference model
        do_reset();
        m_pend = 8'h00; m_en = 8'h00; m_mode = 8'hFF; m_pol = 8'hFF;
        m_nen = 1'b0; m_npend = 1'b0; m_irq = 1'b0; m_nmi = 1'b0;
        m_oe = 1'b0; m_rdata = 8'h00;
        for (int n = 0; n < RCYC; n++) begin
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) nmi_src = ~nmi_src;
            hist[n] = {nmi_src, irq_src};

            d   = 8'($urandom);
            off = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 16'hD008 | 16'(off);
                1:       a = 16'hCFF8 | 16'(off);
                default: a = BASE | 16'(off);
            endcase
            we  = ($urandom_range(0, 9) <= 2);
            rdv = ($urandom_range(0, 9) <= 3);
            bus.addr_pin = a;
            bus.wdata    = d;
            bus.we_pin   = we;
            bus.rd_pin   = rdv;

            cs_m = (a >= BASE) && (a < BASE + 16'd8);
            w    = we && cs_m;
            rr   = rdv && cs_m && !we;
            cur  = (n >= 2) ? hist[n-2] : 9'd0;
            prev = (n >= 3) ? hist[n-3] : 9'd0;

            for (int b = 0; b < 8; b++) begin
                a_now = (cur[b] == m_pol[b]);
                a_prv = (prev[b] == m_pol[b]);
                if (m_mode[b]) begin
                    np[b] = m_pend[b];
                    if (w && off == 3'd0 && d[b]) np[b] = 1'b0;
                    if (a_now && !a_prv) np[b] = 1'b1;
                    if (w && off == 3'd6 && d[b]) np[b] = 1'b1;
                end else begin
                    np[b] = a_now;
                end
            end
            nnp = m_npend;
            if (w && off == 3'd5 && d[1]) nnp = 1'b0;
            if (cur[8] && !prev[8]) nnp = 1'b1;

            m_irq = |(m_pend & m_en);
            m_nmi = m_npend & m_nen;
            if (rr) begin
                m_rdata = m_reg(off);
                m_oe    = 1'b1;
            end else begin
                m_oe = 1'b0;
            end
            if (w) begin
                case (off)
                    3'd1:    m_en   = d;
                    3'd2:    m_mode = d;
                    3'd3:    m_pol  = d;
                    3'd5:    m_nen  = d[0];
                    default: ;
                endcase
            end
            m_pend  = np;
            m_npend = nnp;

            tick();
            check($sformatf("rand%0d", n),
                  32'({irq_out, nmi_out, bus.rdata_oe, bus.rdata}),
                  32'({m_irq, m_nmi, m_oe, m_rdata}));
        end
        bus.we_pin = 1'b0;
        bus.rd_pin = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/irq_ctrl_6502.md
Name: irq_ctrl_6502

Overview:
Memory-mapped interrupt controller sitting upstream of core_6502. It drives the core's irq_in and nmi_in pins and is itself a slave on the core's address/data bus. It synchronises up to 8 external IRQ sources plus one NMI source, applies per-source edge/level mode, polarity and enable masking, and holds pending state until software clears it. It also returns a priority vector for the service routine.

Parameters:
BASE_ADDR, 16'hD000, base of the 8-byte register window; must be 8-byte aligned.
NUM_SRC, 8, number of implemented IRQ sources, 1..8; unimplemented bits read 0 and ignore writes.

Ports:
clk  input  1  system clock, same clock as core_6502
reset  input  1  synchronous, active-high reset
addr_pin  input  16  core address bus
wdata  input  8  core dout
we_pin  input  1  core write strobe
rd_pin  input  1  core read strobe
rdata  output  8  register read data to core din mux
rdata_oe  output  1  rdata valid/drive enable
irq_src  input  NUM_SRC  asynchronous interrupt sources
nmi_src  input  1  asynchronous NMI source, active-high rising edge
irq_out  output  1  to core irq_in, active-high
nmi_out  output  1  to core nmi_in, active-high

Behaviour:
- Reset (synchronous, active-high): rdata=0, rdata_oe=0, irq_out=0, nmi_out=0, PENDING=0, ENABLE=0, MODE=0xFF (edge), POLARITY=0xFF (high/rising), NMI_EN=0, NMI_PEND=0, sync flops=0. Asserting reset mid-transfer discards the access with no side effects.
- cs = (addr_pin[15:3] == BASE_ADDR[15:3]); off = addr_pin[2:0]. Writes apply when we_pin&cs at a clk edge. rd_pin and we_pin together: the write wins and no read is returned.
- Register map:
  - off 0 PENDING: R; W1C, edge-mode bits only.
  - off 1 ENABLE: RW.
  - off 2 MODE: RW; 1=edge, 0=level.
  - off 3 POLARITY: RW; 1=active-high/rising, 0=active-low/falling.
  - off 4 VECTOR: R = {any, 4'b0, idx[2:0]}. any = |(PENDING&ENABLE); idx = lowest-numbered pending&enabled bit (bit 0 highest priority); reads 0x00 when none. Reading does not clear.
  - off 5 NMI_CTRL: bit0 NMI_EN RW; bit1 NMI_PEND R/W1C; other bits read 0.
  - off 6 SWSET: W, each 1 bit sets PENDING for edge-mode sources; reads 0.
  - off 7: reads 0, writes ignored.
- Reads: rd_pin&cs at edge k loads rdata and sets rdata_oe=1 after edge k. rdata_oe drops after edge k+1 unless a new read occurs; rdata holds its last value.
- Synchronisation:
  - Each source passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
  - act = s2 XNOR POLARITY; act_prev = s3 XNOR POLARITY.
  - Edge mode: PENDING bit set when act & !act_prev.
  - Level mode: PENDING bit equals act every cycle; W1C and SWSET have no effect.
- Precedence: a hardware edge set or SWSET in the same cycle as a W1C leaves the bit set (set wins).
- Latency: an input change stable before edge k gives PENDING updated after edge k+2 and irq_out after edge k+3. irq_out is registered as |(PENDING&ENABLE); a write to ENABLE takes effect on irq_out one cycle after the write edge.
- NMI path: rising-edge detection on the synchronised nmi_src sets NMI_PEND. nmi_out is registered as NMI_PEND&NMI_EN and stays high until W1C. A new edge coinciding with a clear keeps NMI_PEND=1.
- Changing MODE or POLARITY does not generate spurious edges: s3 is always compared under the current POLARITY.

Test Plan:
- Reset then read all offsets -> PENDING=0x00, ENABLE=0x00, MODE=0xFF, POLARITY=0xFF, VECTOR=0x00, NMI_CTRL=0x00; irq_out=0, nmi_out=0.
- ENABLE=0x0C; pulse irq_src[3] high for 1 cycle -> PENDING=0x08, irq_out=1 exactly 3 cycles after the pulse edge, VECTOR=0x83; write 0x08 to PENDING -> irq_out=0 one cycle later.
- irq_src[2] and irq_src[3] rise together, ENABLE=0xFF -> VECTOR=0x82; W1C bit 2 -> VECTOR=0x83; W1C bit 3 -> VECTOR=0x00.
- MODE=0xFE, POLARITY=0xFE, ENABLE=0x01; drive irq_src[0] low -> PENDING[0]=1, irq_out=1; W1C 0x01 while low -> stays 1; drive high -> PENDING[0]=0 after 2 cycles.
- W1C of bit 5 issued in the same cycle a rising edge arrives on irq_src[5] -> PENDING[5] remains 1. SWSET 0x40 -> PENDING=0x60.
- NMI_EN=1; rising edge on nmi_src -> nmi_out=1 after 3 cycles; write 0x02 to off 5 -> nmi_out=0. Holding nmi_src high with no new edge -> no re-assert. Reset asserted mid-read -> rdata_oe=0 the next cycle.
